// File: rtl/otter_branch_pkg.sv
// Shared types for the OTTER branch resolver: funct3 encodings, BHT counter
// type and reset value, resolver FSM states, and the saturating counter step.
package otter_branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = 2'b01;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } resolver_state_t;

  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/otter_bht.sv
// Branch history table: 2-bit saturating counters indexed by PC word address,
// one combinational read port (prediction) and one update port (resolution).
module otter_bht
  import otter_branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_rd_taken,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_pc,
  input  logic            i_wr_taken
);

  localparam int IDX_W = $clog2(ENTRIES);

  bht_ctr_t         r_ctr [ENTRIES];
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_unused_pc;

  assign w_rd_idx = i_rd_pc[IDX_W+1:2];
  assign w_wr_idx = i_wr_pc[IDX_W+1:2];

  // Read sees the stored value; a same-cycle update is visible only next cycle.
  assign o_rd_taken = r_ctr[w_rd_idx][1];

  // Byte offset and high PC bits do not take part in indexing.
  assign w_unused_pc = ^{i_rd_pc[XLEN-1:IDX_W+2], i_rd_pc[1:0],
                         i_wr_pc[XLEN-1:IDX_W+2], i_wr_pc[1:0]};

  // NOTE: the counter array must be reset (every entry starts weak not-taken),
  // so it stays in flops rather than a RAM macro; state updates use <= only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= BHT_RESET;
    end else if (i_wr_en) begin
      r_ctr[w_wr_idx] <= bht_next(r_ctr[w_wr_idx], i_wr_taken);
    end
  end

endmodule

// File: rtl/otter_branch_resolver.sv
// Resolves the EX-stage conditional branch, flushes on mispredict and trains the BHT.
// Optional BRANCH_STATS_EN adds saturating resolve/mispredict counters.
module otter_branch_resolver
  import otter_branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int XLEN        = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_pred_taken,
  input  logic            i_stall,
  input  logic            i_ex_valid,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [2:0]      i_ex_funct3,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic            i_br_eq,
  input  logic            i_br_lt,
  input  logic            i_br_ltu,
  output logic            o_flush,
  output logic [XLEN-1:0] o_redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     o_br_count,
  output logic [31:0]     o_misp_count
`endif
);

  resolver_state_t r_state;
  resolver_state_t w_state_nxt;
  logic            r_flush;
  logic [XLEN-1:0] r_redirect_pc;
  logic            w_legal;
  logic            w_taken;
  logic            w_resolve;
  logic            w_mispredict;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_legal = 1'b1;
    w_taken = 1'b0;
    case (i_ex_funct3)
      BEQ:     w_taken = i_br_eq;
      BNE:     w_taken = ~i_br_eq;
      BLT:     w_taken = i_br_lt;
      BGE:     w_taken = ~i_br_lt;
      BLTU:    w_taken = i_br_ltu;
      BGEU:    w_taken = ~i_br_ltu;
      default: w_legal = 1'b0;
    endcase
  end

  // The RECOVER cycle holds a wrong-path instruction, so nothing resolves there.
  assign w_resolve    = i_ex_valid & ~i_stall & (r_state == RUN) & w_legal;
  assign w_mispredict = w_resolve & (w_taken != i_ex_pred_taken);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_mispredict) w_state_nxt = RECOVER;
      RECOVER: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= RUN;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_mispredict;
      if (w_mispredict)
        r_redirect_pc <= w_taken ? i_ex_target : i_ex_pc + XLEN'(4);
    end
  end

  assign o_flush       = r_flush;
  assign o_redirect_pc = r_redirect_pc;

  otter_bht #(
    .ENTRIES (BHT_ENTRIES),
    .XLEN    (XLEN)
  ) u_bht (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_pc    (i_if_pc),
    .o_rd_taken (o_pred_taken),
    .i_wr_en    (w_resolve),
    .i_wr_pc    (i_ex_pc),
    .i_wr_taken (w_taken)
  );

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_misp_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_br_count   <= '0;
      r_misp_count <= '0;
    end else begin
      if (w_resolve && r_br_count != '1)      r_br_count   <= r_br_count + 32'd1;
      if (w_mispredict && r_misp_count != '1) r_misp_count <= r_misp_count + 32'd1;
    end
  end

  assign o_br_count   = r_br_count;
  assign o_misp_count = r_misp_count;
`endif

endmodule

// File: tb/tb_otter_branch_resolver.sv
// Scoreboard bench for otter_branch_resolver: directed cases plus random traffic
// against a reference model built from operand values and branch rules.
`timescale 1ns/1ps
module tb_otter_branch_resolver;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_if_pc;
  logic        o_pred_taken;
  logic        i_stall;
  logic        i_ex_valid;
  logic [31:0] i_ex_pc;
  logic [2:0]  i_ex_funct3;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_target;
  logic        i_br_eq;
  logic        i_br_lt;
  logic        i_br_ltu;
  logic        o_flush;
  logic [31:0] o_redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] o_br_count;
  logic [31:0] o_misp_count;
`endif

  always #5 clk = ~clk;

  otter_branch_resolver #(.BHT_ENTRIES(ENTRIES), .XLEN(32)) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_if_pc         (i_if_pc),
    .o_pred_taken    (o_pred_taken),
    .i_stall         (i_stall),
    .i_ex_valid      (i_ex_valid),
    .i_ex_pc         (i_ex_pc),
    .i_ex_funct3     (i_ex_funct3),
    .i_ex_pred_taken (i_ex_pred_taken),
    .i_ex_target     (i_ex_target),
    .i_br_eq         (i_br_eq),
    .i_br_lt         (i_br_lt),
    .i_br_ltu        (i_br_ltu),
    .o_flush         (o_flush),
    .o_redirect_pc   (o_redirect_pc)
`ifdef BRANCH_STATS_EN
    ,
    .o_br_count      (o_br_count),
    .o_misp_count    (o_misp_count)
`endif
  );

  typedef struct {
    bit          rst;
    logic [31:0] if_pc;
    bit          valid;
    bit          stall;
    logic [31:0] pc;
    logic [2:0]  f3;
    bit          pred;
    logic [31:0] tgt;
    logic [31:0] a;
    logic [31:0] b;
  } stim_t;

  typedef struct {
    int          edge_no;
    logic [31:0] pc;
  } flush_exp_t;

  flush_exp_t  q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  int          ctr [ENTRIES];
  bit          model_init = 1'b0;
  bit          in_recover = 1'b0;
  int unsigned m_br = 0;
  int unsigned m_misp = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return ctr[idx(pc)] >= 2;
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b, output bit legal);
    legal = 1'b1;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: begin legal = 1'b0; return 1'b0; end
    endcase
  endfunction

  function automatic stim_t idle(input logic [31:0] if_pc);
    stim_t s;
    s = '{rst: 1'b0, if_pc: if_pc, valid: 1'b0, stall: 1'b0, pc: 32'h0, f3: 3'd0,
          pred: 1'b0, tgt: 32'h0, a: 32'h0, b: 32'h0};
    return s;
  endfunction

  function automatic stim_t br(input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] tgt, input logic [31:0] a,
                               input logic [31:0] b, input bit pred);
    stim_t s;
    s = '{rst: 1'b0, if_pc: pc, valid: 1'b1, stall: 1'b0, pc: pc, f3: f3,
          pred: pred, tgt: tgt, a: a, b: b};
    return s;
  endfunction

  // Drive one cycle, check the prediction, advance the model, wait for next negedge.
  task automatic step(input stim_t s);
    bit legal;
    bit taken;
    i_rst           = s.rst;
    i_if_pc         = s.if_pc;
    i_stall         = s.stall;
    i_ex_valid      = s.valid;
    i_ex_pc         = s.pc;
    i_ex_funct3     = s.f3;
    i_ex_pred_taken = s.pred;
    i_ex_target     = s.tgt;
    i_br_eq         = (s.a == s.b);
    i_br_lt         = ($signed(s.a) < $signed(s.b));
    i_br_ltu        = (s.a < s.b);
    #1;
    if (model_init) check("pred_taken", {31'b0, o_pred_taken}, {31'b0, model_pred(s.if_pc)});
    if (s.rst) begin
      foreach (ctr[i]) ctr[i] = 1;
      in_recover = 1'b0;
      m_br       = 0;
      m_misp     = 0;
      model_init = 1'b1;
    end else if (in_recover) begin
      in_recover = 1'b0;
    end else if (s.valid && !s.stall) begin
      taken = ref_taken(s.f3, s.a, s.b, legal);
      if (legal) begin
        m_br++;
        ctr[idx(s.pc)] = taken ? ((ctr[idx(s.pc)] < 3) ? ctr[idx(s.pc)] + 1 : 3)
                               : ((ctr[idx(s.pc)] > 0) ? ctr[idx(s.pc)] - 1 : 0);
        if (taken != s.pred) begin
          q.push_back('{edge_no: edge_cnt + 1, pc: taken ? s.tgt : s.pc + 32'd4});
          in_recover = 1'b1;
          m_misp++;
        end
      end
    end
    @(negedge clk);
  endtask

  // Monitor: every flush pulse must match the oldest expected one, on its edge.
  initial begin
    flush_exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (o_flush === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL flush_unexpected: got flush=1 redirect=0x%08h at edge %0d, expected no flush",
                   o_redirect_pc, edge_cnt);
        end else begin
          e = q.pop_front();
          check("flush_edge", edge_cnt, e.edge_no);
          check("redirect_pc", o_redirect_pc, e.pc);
        end
      end
    end
  end

  initial begin
    stim_t       s;
    logic [31:0] pcs [8];
    pcs = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h300, 32'h3FC, 32'hFFFF_FFFC, 32'h1000};

    i_rst = 1'b1; i_if_pc = '0; i_stall = 1'b0; i_ex_valid = 1'b0; i_ex_pc = '0;
    i_ex_funct3 = '0; i_ex_pred_taken = 1'b0; i_ex_target = '0;
    i_br_eq = 1'b0; i_br_lt = 1'b0; i_br_ltu = 1'b0;
    @(negedge clk);

    s = idle(32'h0); s.rst = 1'b1;
    step(s); step(s);
    check("flush_reset", {31'b0, o_flush}, 32'h0);
    check("redirect_reset", o_redirect_pc, 32'h0);
    for (int i = 0; i < ENTRIES; i++) step(idle(32'(i * 4)));

    // BEQ taken, predicted not-taken.
    step(br(3'd0, 32'h100, 32'h140, 32'd5, 32'd5, 1'b0));
    step(idle(32'h100));

    // BNE not taken three times, then one taken: counter must have floored at 00.
    repeat (3) step(br(3'd1, 32'h300, 32'h340, 32'd7, 32'd7, 1'b0));
    step(br(3'd1, 32'h300, 32'h340, 32'd7, 32'd8, 1'b0));
    step(idle(32'h300));

    // BLTU taken 3x following the predictor, then one not-taken: stays predicted taken.
    repeat (3) begin
      step(br(3'd6, 32'h200, 32'h280, 32'd1, 32'd2, model_pred(32'h200)));
      step(idle(32'h200));
    end
    step(br(3'd6, 32'h200, 32'h280, 32'd2, 32'd1, model_pred(32'h200)));
    step(idle(32'h200));

    // Second mispredict arriving during RECOVER is ignored.
    step(br(3'd0, 32'h400, 32'h500, 32'd3, 32'd3, 1'b0));
    step(br(3'd1, 32'h404, 32'h600, 32'd3, 32'd4, 1'b0));
    step(idle(32'h0)); step(idle(32'h0));

    // Stalled mispredict resolves only once the stall drops.
    s = br(3'd4, 32'h500, 32'h540, 32'hFFFF_FFFF, 32'd0, 1'b0);
    s.stall = 1'b1;
    repeat (3) step(s);
    s.stall = 1'b0;
    step(s);
    step(idle(32'h0));

    // Reset in the same cycle as a mispredict: no flush, counters back to 01.
    s = br(3'd0, 32'h600, 32'h640, 32'd9, 32'd9, 1'b0);
    s.rst = 1'b1;
    step(s);
    for (int i = 0; i < ENTRIES; i++) step(idle(32'(i * 4)));

    // Illegal funct3 at the top of the address space, then BGE not-taken wraps PC+4.
    step(br(3'd2, 32'hFFFF_FFFC, 32'h10, 32'd1, 32'd1, 1'b1));
    step(idle(32'hFFFF_FFFC));
    step(br(3'd5, 32'hFFFF_FFFC, 32'h20, 32'hFFFF_FFFF, 32'd0, 1'b1));
    step(idle(32'hFFFF_FFFC));

    for (int n = 0; n < 3000; n++) begin
      s.rst   = ($urandom_range(0, 299) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.pc    = pcs[$urandom_range(0, 7)];
      s.if_pc = ($urandom_range(0, 2) == 0) ? s.pc : pcs[$urandom_range(0, 7)];
      s.f3    = 3'($urandom_range(0, 7));
      s.pred  = ($urandom_range(0, 1) == 0) ? model_pred(s.pc) : 1'($urandom_range(0, 1));
      s.tgt   = $urandom & 32'hFFFF_FFFC;
      s.a     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      s.b     = ($urandom_range(0, 2) == 0) ? s.a : $urandom;
      step(s);
    end

    repeat (4) step(idle(32'h0));
    check("pending_flush", q.size(), 32'h0);
`ifdef BRANCH_STATS_EN
    check("br_count", o_br_count, m_br);
    check("misp_count", o_misp_count, m_misp);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
